// File: rtl/seq_detect_arbiter.sv
// Round-robin shared "1011" overlapping Mealy detector across N_CH serial lanes.
// Per-channel progress lives in a small state table; hits are tagged and counted.
module seq_detect_arbiter #(
    parameter int N_CH = 4,
    parameter int CNT_W = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       req_valid,
    input  logic [N_CH-1:0]       req_bit,
    output logic [N_CH-1:0]       req_ready,
    input  logic [N_CH-1:0]       ch_clear,
    output logic                  hit_valid,
    output logic [CH_W-1:0]       hit_ch,
    output logic [N_CH*CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G10  = 2'd2,
        G101 = 2'd3
    } st_t;

    st_t              st  [N_CH];
    logic [CNT_W-1:0] cnt [N_CH];
    logic [CH_W-1:0]  ptr;

    logic [N_CH-1:0]  eligible;
    logic             gnt_any;
    logic [CH_W-1:0]  gnt_ch;
    logic             gnt_bit;
    logic             hit;

    // Sums never exceed 2*N_CH-2, so one conditional subtract is a full modulo.
    function automatic logic [CH_W-1:0] wrap(input logic [CH_W:0] v);
        logic [CH_W:0] r;
        r = (v >= (CH_W+1)'(N_CH)) ? v - (CH_W+1)'(N_CH) : v;
        return r[CH_W-1:0];
    endfunction

    function automatic st_t nxt(input st_t s, input logic b);
        st_t n;
        unique case (s)
            IDLE:    n = b ? G1 : IDLE;
            G1:      n = b ? G1 : G10;
            G10:     n = b ? G101 : IDLE;
            G101:    n = b ? G1 : G10;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    assign eligible = req_valid & ~ch_clear;

    always_comb begin
        logic [CH_W-1:0] idx;
        gnt_any   = 1'b0;
        gnt_ch    = '0;
        req_ready = '0;
        idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = wrap({1'b0, ptr} + (CH_W+1)'(i));
            if (!gnt_any && eligible[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = idx;
            end
        end
        if (gnt_any) req_ready[gnt_ch] = 1'b1;
    end

    assign gnt_bit = req_bit[gnt_ch];
    assign hit     = gnt_any && (st[gnt_ch] == G101) && gnt_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            hit_valid <= 1'b0;
            hit_ch    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                st[c]  <= IDLE;
                cnt[c] <= '0;
            end
        end else begin
            hit_valid <= hit;
            if (hit) hit_ch <= gnt_ch;
            if (gnt_any) ptr <= wrap({1'b0, gnt_ch} + (CH_W+1)'(1));
            for (int c = 0; c < N_CH; c++) begin
                if (ch_clear[c]) begin
                    st[c]  <= IDLE;
                    cnt[c] <= '0;
                end else if (req_ready[c]) begin
                    st[c] <= nxt(st[c], req_bit[c]);
                    if (hit && cnt[c] != '1) cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_cnt
        assign hit_count[c*CNT_W +: CNT_W] = cnt[c];
    end

endmodule
